// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU and load results into one in-order register-file write stream.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data   ALU result handshake (backpressured)
//   mem_valid/mem_rd/mem_data     load result (always accepted)
//   w_ctrl_reg/w_addr_reg/w_data_reg      registered register-file write port
//   q_addr1/q_hit1/q_data1        forwarding query port 1 (combinational)
//   q_addr2/q_hit2/q_data2        forwarding query port 2 (combinational)
//   pending_count                 FIFO occupancy, excluding the w_* stage
module wb_write_arbiter #(
    parameter int REGISTER_COUNT = 32,
    parameter int DATA_LENGTH    = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [$clog2(REGISTER_COUNT)-1:0] alu_rd,
    input  logic [DATA_LENGTH-1:0]            alu_data,
    input  logic                              mem_valid,
    input  logic [$clog2(REGISTER_COUNT)-1:0] mem_rd,
    input  logic [DATA_LENGTH-1:0]            mem_data,
    output logic                              w_ctrl_reg,
    output logic [$clog2(REGISTER_COUNT)-1:0] w_addr_reg,
    output logic [DATA_LENGTH-1:0]            w_data_reg,
    input  logic [$clog2(REGISTER_COUNT)-1:0] q_addr1,
    input  logic [$clog2(REGISTER_COUNT)-1:0] q_addr2,
    output logic                              q_hit1,
    output logic                              q_hit2,
    output logic [DATA_LENGTH-1:0]            q_data1,
    output logic [DATA_LENGTH-1:0]            q_data2,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_count
);
    localparam int AW = $clog2(REGISTER_COUNT);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    typedef struct packed {
        logic [AW-1:0]          rd;
        logic [DATA_LENGTH-1:0] data;
    } ent_t;
    ent_t          fifo_q [FIFO_DEPTH];
    ent_t          fifo_d [FIFO_DEPTH];
    ent_t          comb   [FIFO_DEPTH+1];
    ent_t          mem_e, alu_e, first;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   total;
    logic          mem_push, alu_push, avail;
    // Keeping two free slots guarantees room for a same-cycle mem + ALU push.
    assign alu_ready     = !rst && (cnt_q <= CW'(FIFO_DEPTH-2));
    assign mem_push      = mem_valid && (mem_rd != '0);
    assign alu_push      = alu_valid && alu_ready && (alu_rd != '0);
    assign mem_e         = '{rd: mem_rd, data: mem_data};
    assign alu_e         = '{rd: alu_rd, data: alu_data};
    assign pending_count = cnt_q;
    // Logical queue = stored entries, then the mem push, then the ALU push;
    // slot 0 is the oldest and drains this cycle when anything is present.
    always_comb begin
        first = mem_push ? mem_e : alu_e;
        total = {1'b0, cnt_q} + (CW+1)'(mem_push) + (CW+1)'(alu_push);
        avail = total != '0;
        for (int i = 0; i <= FIFO_DEPTH; i++)
            comb[i] = (i == int'(cnt_q)) ? first : alu_e;
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (i < int'(cnt_q)) comb[i] = fifo_q[i];
        for (int i = 0; i < FIFO_DEPTH; i++)
            fifo_d[i] = avail ? comb[i+1] : comb[i];
        cnt_d = CW'(total - (CW+1)'(avail));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            w_ctrl_reg <= 1'b0;
            w_addr_reg <= '0;
            w_data_reg <= '0;
        end else begin
            cnt_q      <= cnt_d;
            fifo_q     <= fifo_d;
            w_ctrl_reg <= avail;
            if (avail) begin
                w_addr_reg <= comb[0].rd;
                w_data_reg <= comb[0].data;
            end
        end
    end
    // Later matches overwrite earlier ones, so the youngest pending write wins.
    function automatic logic [DATA_LENGTH:0] fwd(input logic [AW-1:0] q);
        logic [DATA_LENGTH:0] r;
        r = '0;
        if (w_ctrl_reg && w_addr_reg == q) r = {1'b1, w_data_reg};
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (i < int'(cnt_q) && fifo_q[i].rd == q) r = {1'b1, fifo_q[i].data};
        return (q == '0) ? '0 : r;
    endfunction
    always_comb begin
        {q_hit1, q_data1} = fwd(q_addr1);
        {q_hit2, q_data2} = fwd(q_addr2);
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: table-driven and scoreboard checks of wb_write_arbiter.
module tb_wb_write_arbiter;
    localparam int D = 4;
    logic        clk = 0;
    logic        rst, alu_valid, alu_ready, mem_valid, w_ctrl_reg, q_hit1, q_hit2;
    logic [4:0]  alu_rd, mem_rd, w_addr_reg, q_addr1, q_addr2;
    logic [31:0] alu_data, mem_data, w_data_reg, q_data1, q_data2;
    logic [2:0]  pending_count;
    int          total = 0, bad = 0;
    always #5 clk = ~clk;
    wb_write_arbiter #(.REGISTER_COUNT(32), .DATA_LENGTH(32), .FIFO_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .w_ctrl_reg(w_ctrl_reg), .w_addr_reg(w_addr_reg), .w_data_reg(w_data_reg),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2), .pending_count(pending_count)
    );
    typedef struct {
        logic        rst, mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic [4:0]  q1, q2;
        logic        e_rdy, e_wc;
        int          e_cnt;
    } vec_t;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;
    ent_t pend[$];
    ent_t stage;
    bit   stage_v = 0;
    vec_t tbl [24];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask
    function automatic void fwd(input logic [4:0] q, output logic h, output logic [31:0] d);
        h = 0;
        d = 0;
        if (q != 0) begin
            if (stage_v && stage.rd == q) begin h = 1; d = stage.data; end
            foreach (pend[i]) if (pend[i].rd == q) begin h = 1; d = pend[i].data; end
        end
    endfunction
    task automatic step(input vec_t v, input bit use_exp);
        bit          rdy_m;
        logic        h;
        logic [31:0] d;
        rst = v.rst; mem_valid = v.mv; mem_rd = v.mr; mem_data = v.md;
        alu_valid = v.av; alu_rd = v.ar; alu_data = v.ad; q_addr1 = v.q1; q_addr2 = v.q2;
        #1;
        rdy_m = !v.rst && pend.size() <= D-2;
        chk("alu_ready", alu_ready, rdy_m);
        if (use_exp) chk("tbl_alu_ready", alu_ready, v.e_rdy);
        if (v.rst) pend.delete();
        else begin
            if (v.mv && v.mr != 0) pend.push_back('{v.mr, v.md});
            if (v.av && rdy_m && v.ar != 0) pend.push_back('{v.ar, v.ad});
        end
        @(posedge clk);
        @(negedge clk);
        stage_v = pend.size() != 0;
        chk("w_ctrl_reg", w_ctrl_reg, stage_v);
        if (stage_v) begin
            stage = pend.pop_front();
            if (w_ctrl_reg) begin
                chk("w_addr_reg", w_addr_reg, stage.rd);
                chk("w_data_reg", w_data_reg, stage.data);
            end
        end
        chk("no_overflow", pend.size() <= D, 1);
        chk("pending_count", pending_count, pend.size());
        if (use_exp) begin
            chk("tbl_w_ctrl", w_ctrl_reg, v.e_wc);
            chk("tbl_count", pending_count, v.e_cnt);
        end
        fwd(q_addr1, h, d);
        chk("q_hit1", q_hit1, h);
        chk("q_data1", q_data1, d);
        fwd(q_addr2, h, d);
        chk("q_hit2", q_hit2, h);
        chk("q_data2", q_data2, d);
    endtask
    initial begin
        vec_t v;
        tbl[0]  = '{1, 0, 0, 0,     0, 0, 0,            0, 0,  0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0,     1, 5, 32'hDEADBEEF, 5, 0,  1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0,     0, 0, 0,            5, 0,  1, 0, 0};
        tbl[3]  = '{0, 1, 3, 32'h11, 1, 3, 32'h22,      3, 5,  1, 1, 1};
        tbl[4]  = '{0, 0, 0, 0,     0, 0, 0,            3, 0,  1, 1, 0};
        tbl[5]  = '{0, 0, 0, 0,     0, 0, 0,            3, 0,  1, 0, 0};
        tbl[6]  = '{0, 0, 0, 0,     1, 0, 32'hFFFFFFFF, 0, 0,  1, 0, 0};
        tbl[7]  = '{0, 0, 0, 0,     0, 0, 0,            0, 0,  1, 0, 0};
        tbl[8]  = '{0, 1, 1, 32'h100, 1, 2, 32'h200,    1, 2,  1, 1, 1};
        tbl[9]  = '{0, 1, 3, 32'h300, 1, 4, 32'h400,    2, 4,  1, 1, 2};
        tbl[10] = '{0, 1, 5, 32'h500, 1, 6, 32'h600,    4, 6,  1, 1, 3};
        tbl[11] = '{0, 1, 7, 32'h700, 1, 8, 32'h800,    6, 8,  0, 1, 3};
        tbl[12] = '{0, 1, 9, 32'h900, 1, 10, 32'hA00,   7, 10, 0, 1, 3};
        tbl[13] = '{0, 1, 11, 32'hB00, 1, 12, 32'hC00,  9, 12, 0, 1, 3};
        tbl[14] = '{0, 0, 0, 0,     0, 0, 0,            9, 11, 0, 1, 2};
        tbl[15] = '{0, 0, 0, 0,     0, 0, 0,            9, 11, 1, 1, 1};
        tbl[16] = '{0, 0, 0, 0,     0, 0, 0,            11, 9, 1, 1, 0};
        tbl[17] = '{0, 0, 0, 0,     0, 0, 0,            11, 9, 1, 0, 0};
        tbl[18] = '{0, 1, 7, 32'h7000, 1, 8, 32'h8000,  7, 8,  1, 1, 1};
        tbl[19] = '{0, 1, 9, 32'h9000, 1, 10, 32'hA000, 8, 10, 1, 1, 2};
        tbl[20] = '{0, 1, 11, 32'hB000, 1, 12, 32'hC000, 11, 12, 1, 1, 3};
        tbl[21] = '{1, 1, 13, 32'hD000, 1, 14, 32'hE000, 11, 12, 0, 0, 0};
        tbl[22] = '{0, 0, 0, 0,     0, 0, 0,            12, 11, 1, 0, 0};
        tbl[23] = '{0, 0, 0, 0,     0, 0, 0,            13, 14, 1, 0, 0};
        foreach (tbl[i]) step(tbl[i], 1);
        for (int n = 0; n < 80; n++) begin
            v = '{0, 1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 0, 0, 0};
            v.rst = (n == 40);
            step(v, 0);
        end
        v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int n = 0; n < 6; n++) step(v, 0);
        v.rst = 1;
        step(v, 0);
        for (int a = 0; a < 32; a++) begin
            q_addr1 = 5'(a);
            q_addr2 = 5'(31 - a);
            #1;
            chk("idle_q_hit1", q_hit1, 0);
            chk("idle_q_hit2", q_hit2, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writeback-side producer that drives the register file write port (w_ctrl_reg / w_addr_reg / w_data_reg).
- Merges results from the ALU path and the load (memory) path into a single in-order write stream through a small FIFO, one write per cycle.
- Drops writes to x0.
- Provides two combinational forwarding query ports, so decode can read values that are still pending and not yet committed to the register file.

Parameters:
REGISTER_COUNT, 32, number of architectural registers; address width is $clog2(REGISTER_COUNT)
DATA_LENGTH, 32, register data width
FIFO_DEPTH, 4, pending-write buffer entries; must be >= 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
alu_valid  input  1  ALU result present this cycle
alu_ready  output  1  ALU result accepted when alu_valid & alu_ready
alu_rd  input  $clog2(REGISTER_COUNT)  ALU destination register
alu_data  input  DATA_LENGTH  ALU result
mem_valid  input  1  load result present; always accepted, no backpressure
mem_rd  input  $clog2(REGISTER_COUNT)  load destination register
mem_data  input  DATA_LENGTH  load result
w_ctrl_reg  output  1  register file write enable, registered
w_addr_reg  output  $clog2(REGISTER_COUNT)  write address, registered
w_data_reg  output  DATA_LENGTH  write data, registered
q_addr1, q_addr2  input  $clog2(REGISTER_COUNT)  forwarding query addresses
q_hit1, q_hit2  output  1  a pending, uncommitted write to q_addrN exists
q_data1, q_data2  output  DATA_LENGTH  data of youngest pending write to q_addrN; 0 when no hit
pending_count  output  $clog2(FIFO_DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - FIFO emptied; pending_count=0.
  - w_ctrl_reg=0, w_addr_reg=0, w_data_reg=0.
  - All pending entries are discarded with no write issued, including when reset arrives mid-stream.
  - alu_ready=0 while rst=1.
- Acceptance per cycle:
  - mem accepted if mem_valid.
  - ALU accepted if alu_valid & alu_ready.
  - An accepted result with rd==0 is dropped: no enqueue, no write.
- Enqueue order:
  - When both are accepted in the same cycle, the mem entry is older than the ALU entry. The upstream contract is that a same-cycle load is earlier in program order.
  - Up to 2 pushes and at most 1 pop per cycle.
- Drain: each cycle with ≥1 entry available (FIFO contents, or a push into an empty FIFO via bypass), the oldest entry is loaded into the w_* registers with w_ctrl_reg=1; otherwise w_ctrl_reg=0.
  - Latency: a result accepted at edge N with an empty FIFO is presented on w_* after edge N, i.e. committed at edge N+1.
  - Write order equals acceptance order.
- alu_ready = !rst && (pending_count <= FIFO_DEPTH-2), combinational from registered count.
  - This guarantees space for a mem push plus an ALU push.
  - A mem push always fits: at full occupancy a pop occurs in the same cycle.
  - Overflow never occurs. Bench asserts on attempted overflow.
- w_addr_reg and w_data_reg hold their last value when w_ctrl_reg=0.
- Forwarding (combinational):
  - Searched set: current w_* entry if w_ctrl_reg=1 (it commits at the next edge), plus all FIFO entries.
  - Entries accepted in the current cycle are not searched.
  - Youngest match wins.
  - q_addrN==0 never hits.
  - Hit means the register file value for that address is stale.
- pending_count counts FIFO entries only, excluding the w_* stage.

Test Plan:
- Reset then single ALU write rd=5 data=0xDEADBEEF -> next cycle w_ctrl_reg=1, w_addr_reg=5, w_data_reg=0xDEADBEEF; following cycle w_ctrl_reg=0; q_addr1=5 hits 0xDEADBEEF only while w_ctrl_reg=1.
- Same cycle mem rd=3 data=0x11 and ALU rd=3 data=0x22 -> writes 0x11 then 0x22 on consecutive cycles; during the first, q_addr1=3 returns 0x22 (youngest).
- ALU rd=0 data=0xFFFFFFFF alone -> no write ever issued; q_addr1=0 never hits; pending_count stays 0.
- FIFO_DEPTH=4, mem+ALU valid every cycle for 6 cycles -> alu_ready falls once count>2; no entry lost; all writes in acceptance order; one write per cycle until drained.
- Fill to pending_count=3, assert rst one cycle -> next cycle pending_count=0, w_ctrl_reg=0, no further writes, q_hit1/q_hit2=0 for all addresses.
